// File: rtl/maddsub_sequencer_pkg.sv
// Shared encodings for the MULT/MADD/MSUB sequencer: op codes, one-hot FSM
// states and the op-to-slice-control decode.
package maddsub_sequencer_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MADD = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_MUL    = 6'b000010,
    ST_LOAD   = 6'b000100,
    ST_SUM_LO = 6'b001000,
    ST_SUM_HI = 6'b010000,
    ST_DONE   = 6'b100000
  } state_e;

  typedef struct packed {
    logic c_zero;
    logic subtract;
  } op_ctl_t;

  // The reserved encoding falls into the MULT arm.
  function automatic op_ctl_t decode_op(input logic [1:0] op);
    op_ctl_t ctl;
    case (op)
      OP_MADD: ctl = '{c_zero: 1'b0, subtract: 1'b0};
      OP_MSUB: ctl = '{c_zero: 1'b0, subtract: 1'b1};
      default: ctl = '{c_zero: 1'b1, subtract: 1'b0};
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/maddsub_sequencer_if.sv
// Request/response handshake between the MULT/MADD/MSUB issue point, the
// sequencer and the HI/LO write-back.
interface maddsub_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_sign;
  logic        abort;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_result;

  modport slave (
    input  req_valid, req_op, req_sign, abort, resp_ready,
    output req_ready, resp_valid, resp_result
  );

  modport master (
    output req_valid, req_op, req_sign, abort, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/maddsub_sequencer.sv
// Walks one multiply / multiply-accumulate through the multiplier and the
// low (47:0) and high (63:48) add/sub slices, then hands the 64-bit result on.
module maddsub_sequencer
  import maddsub_sequencer_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  maddsub_sequencer_if.slave        bus,
  output logic                      mul_ce,
  output logic                      c_zero,
  output logic                      subtract,
  output logic                      sign,
  output logic                      lo_ceb,
  output logic                      lo_cec,
  output logic                      lo_ceopmode,
  output logic                      lo_cep,
  output logic                      hi_ceb,
  output logic                      hi_cec,
  output logic                      hi_ceopmode,
  output logic                      hi_cep,
  output logic                      hi_carryin,
  input  logic [48:0]               lo_sum,
  input  logic [16:0]               hi_sum
);

  localparam int                CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic             mul_q;
  logic             load_q;
  logic             sum_lo_q;
  logic             sum_hi_q;
  logic             c_zero_q;
  logic             subtract_q;
  logic             sign_q;

  logic             accept_s;
  logic             ce_gate_s;
  op_ctl_t          req_ctl_s;
  logic             unused_hi_msb_s;

  assign accept_s  = (state_q == ST_IDLE) & req_ready_q & bus.req_valid & ~bus.abort;
  assign ce_gate_s = ~bus.abort;
  assign req_ctl_s = decode_op(bus.req_op);

  // Sequencer FSM; every control it produces is held in a flop of its own.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      mul_q        <= 1'b0;
      load_q       <= 1'b0;
      sum_lo_q     <= 1'b0;
      sum_hi_q     <= 1'b0;
      c_zero_q     <= 1'b0;
      subtract_q   <= 1'b0;
      sign_q       <= 1'b0;
    end else if (bus.abort && (state_q != ST_IDLE)) begin
      // A flush drops whatever is in flight, including an unaccepted response.
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mul_q        <= 1'b0;
      load_q       <= 1'b0;
      sum_lo_q     <= 1'b0;
      sum_hi_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q     <= ST_MUL;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            mul_q       <= 1'b1;
            c_zero_q    <= req_ctl_s.c_zero;
            subtract_q  <= req_ctl_s.subtract;
            sign_q      <= bus.req_sign;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_MUL: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= ST_LOAD;
            mul_q   <= 1'b0;
            load_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - CNT_ONE;
          end
        end
        ST_LOAD: begin
          state_q  <= ST_SUM_LO;
          load_q   <= 1'b0;
          sum_lo_q <= 1'b1;
        end
        ST_SUM_LO: begin
          state_q  <= ST_SUM_HI;
          sum_lo_q <= 1'b0;
          sum_hi_q <= 1'b1;
        end
        ST_SUM_HI: begin
          state_q      <= ST_DONE;
          sum_hi_q     <= 1'b0;
          resp_valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (bus.resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end else begin
            state_q      <= ST_DONE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          cnt_q        <= CNT_ZERO;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          mul_q        <= 1'b0;
          load_q       <= 1'b0;
          sum_lo_q     <= 1'b0;
          sum_hi_q     <= 1'b0;
        end
      endcase
    end
  end

  // The accept cycle already clocks the multiplier; abort masks every enable at once.
  assign mul_ce      = (accept_s | mul_q) & ce_gate_s;
  assign lo_ceb      = load_q   & ce_gate_s;
  assign lo_cec      = load_q   & ce_gate_s;
  assign lo_ceopmode = load_q   & ce_gate_s;
  assign hi_ceb      = load_q   & ce_gate_s;
  assign hi_cec      = load_q   & ce_gate_s;
  assign hi_ceopmode = load_q   & ce_gate_s;
  assign lo_cep      = sum_lo_q & ce_gate_s;
  assign hi_cep      = sum_hi_q & ce_gate_s;

  // Low P register bit 48 is carry for add and borrow for subtract alike.
  assign hi_carryin  = sum_hi_q & lo_sum[48];

  assign c_zero      = c_zero_q;
  assign subtract    = subtract_q;
  assign sign        = sign_q;

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = {hi_sum[15:0], lo_sum[47:0]};

  // Overflow out of bit 63 is discarded.
  assign unused_hi_msb_s = hi_sum[16];

endmodule
